uart_tx_buffer: RTL



---
 rtl/uart_tx_buffer_pkg.sv | 25 ++
 rtl/sync_fifo_byte.sv | 83 ++++++++
 rtl/uart_tx_buffer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/uart_tx_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_buffer_pkg
// Brief   : Shared constants and send-FSM state encoding for uart_tx_buffer.
// Revision: 1.0 - initial release
// ============================================================================
package uart_tx_buffer_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_LO = 2'd1,
        ST_WAIT_HI = 2'd2,
        ST_LF      = 2'd3
    } tx_state_e;

    // True when a popped byte must be followed by an automatic line feed.
    function automatic logic needs_lf(input logic add_lf, input logic [7:0] b);
        return add_lf && (b == ASCII_CR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_byte.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo_byte
// Brief   : Byte-wide synchronous FIFO, first-word fall-through, with
//           registered occupancy, full and empty flags.
// Revision: 1.0 - initial release
// ============================================================================
module sync_fifo_byte #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [7:0]    din_i,
    output logic [7:0]    dout_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam logic [AW:0] C_FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          full_q;
    logic          empty_q;
    logic          w_push;
    logic          w_pop;

    // Qualify requests against the flags as they stand at the start of the cycle.
    assign w_push = push_i & ~full_q;
    assign w_pop  = pop_i  & ~empty_q;

    // Next occupancy: simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + 1'b1;
        end else if (!w_push && w_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage array; contents need no reset since empty gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers wrap naturally at DEPTH; flags are derived from the next count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == C_FULL_CNT);
            empty_q <= (count_d == '0);
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffer.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_buffer
// Brief   : Byte FIFO plus send-handshake FSM feeding a UART transmitter,
//           with optional CR -> CR+LF expansion, handshake timeout and a
//           sticky overflow flag.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_buffer
    import uart_tx_buffer_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter bit ADD_LF  = 1'b1,
    parameter int BUSY_TO = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    wr_data_i,
    input  logic          wr_en_i,
    input  logic          tx_ready_i,
    output logic [7:0]    tx_dat_o,
    output logic          tx_send_o,
    input  logic          ovf_clr_i,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          overflow_o
);

    localparam int                C_TMO_W    = (BUSY_TO < 2) ? 1 : $clog2(BUSY_TO + 1);
    localparam logic [C_TMO_W-1:0] C_TMO_LOAD = C_TMO_W'(BUSY_TO);

    tx_state_e          state_q;
    logic [7:0]         tx_dat_q;
    logic               tx_send_q;
    logic               lf_pend_q;
    logic [C_TMO_W-1:0] tmo_q;
    logic               overflow_q;
    logic               overflow_d;

    logic [7:0]         w_fifo_dout;
    logic [AW:0]        w_fifo_count;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_pop;

    // Only an idle FSM with a ready UART consumes the head byte.
    assign w_pop = (state_q == ST_IDLE) && !w_fifo_empty && tx_ready_i;

    sync_fifo_byte #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (wr_en_i),
        .pop_i   (w_pop),
        .din_i   (wr_data_i),
        .dout_o  (w_fifo_dout),
        .count_o (w_fifo_count),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    // Sticky overflow: a dropped push wins over a simultaneous clear.
    always_comb begin
        overflow_d = overflow_q;
        if (ovf_clr_i) begin
            overflow_d = 1'b0;
        end
        if (wr_en_i && w_fifo_full) begin
            overflow_d = 1'b1;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    // Send FSM: pop/send, wait for busy (or timeout), wait for ready, optional LF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tx_dat_q  <= 8'h00;
            tx_send_q <= 1'b0;
            lf_pend_q <= 1'b0;
            tmo_q     <= '0;
        end else begin
            tx_send_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_pop) begin
                        tx_dat_q  <= w_fifo_dout;
                        tx_send_q <= 1'b1;
                        tmo_q     <= C_TMO_LOAD;
                        lf_pend_q <= needs_lf(ADD_LF, w_fifo_dout);
                        state_q   <= ST_WAIT_LO;
                    end
                end
                ST_WAIT_LO: begin
                    // A UART that never drops ready must not stall the queue.
                    if (!tx_ready_i || (tmo_q == '0)) begin
                        state_q <= ST_WAIT_HI;
                    end else begin
                        tmo_q <= tmo_q - 1'b1;
                    end
                end
                ST_WAIT_HI: begin
                    if (tx_ready_i) begin
                        state_q <= lf_pend_q ? ST_LF : ST_IDLE;
                    end
                end
                ST_LF: begin
                    tx_dat_q  <= ASCII_LF;
                    tx_send_q <= 1'b1;
                    lf_pend_q <= 1'b0;
                    tmo_q     <= C_TMO_LOAD;
                    state_q   <= ST_WAIT_LO;
                end
            endcase
        end
    end

    assign tx_dat_o   = tx_dat_q;
    assign tx_send_o  = tx_send_q;
    assign count_o    = w_fifo_count;
    assign full_o     = w_fifo_full;
    assign empty_o    = w_fifo_empty;
    assign overflow_o = overflow_q;

endmodule
`default_nettype wire
